// File: rtl/fp_pkg.sv
// Shared types and helpers for the FP multiplier back-end: operand class, rounding mode,
// flag bit positions and width functions of the word size N.
package fp_pkg;

    typedef enum logic [1:0] {
        FP_NORM = 2'b00,
        FP_ZERO = 2'b01,
        FP_INF  = 2'b10,
        FP_NAN  = 2'b11
    } fp_class_e;

    typedef enum logic [1:0] {
        RND_RNE = 2'b00,
        RND_RTZ = 2'b01,
        RND_RUP = 2'b10,
        RND_RDN = 2'b11
    } fp_rnd_e;

    // Positions within the {inexact, underflow, overflow, nan} flag vector
    localparam int FLG_NAN = 0;
    localparam int FLG_OVF = 1;
    localparam int FLG_UNF = 2;
    localparam int FLG_INX = 3;

    function automatic int fp_m(input int n);
        return (n == 64) ? 52 : 23;
    endfunction

    function automatic int fp_e(input int n);
        return (n == 64) ? 11 : 8;
    endfunction

    function automatic int fp_bias(input int n);
        return (n == 64) ? 1023 : 127;
    endfunction

endpackage

// File: rtl/fp_round_core.sv
// Combinational rounder: applies the rounding increment to the stored fraction and reports
// the carry-out when an all-ones fraction rolls over to the next binade.
module fp_round_core
    import fp_pkg::*;
#(
    parameter int M = 23
) (
    input  logic [M-1:0] i_frac,
    input  logic         i_guard,
    input  logic         i_sticky,
    input  logic         i_sign,
    input  fp_rnd_e      i_mode,
    output logic [M-1:0] o_frac,
    output logic         o_carry
);

    logic w_up;

    always_comb begin
        w_up = 1'b0;
        case (i_mode)
            RND_RNE: w_up = i_guard & (i_sticky | i_frac[0]);
            RND_RTZ: w_up = 1'b0;
            RND_RUP: w_up = ~i_sign & (i_guard | i_sticky);
            RND_RDN: w_up = i_sign & (i_guard | i_sticky);
            default: w_up = 1'b0;
        endcase
    end

    // Hidden bit is always 1, so a wrap of the fraction means the significand became 2.0
    assign o_frac  = i_frac + M'(w_up);
    assign o_carry = w_up & (&i_frac);

endmodule

// File: rtl/fp_mul_round_norm.sv
// Two-stage normalise/round/saturate back-end for the FP multiplier (valid/ready pipeline).
// Optional FP_RND_MODE_EN adds a per-operand rounding-mode port; otherwise fixed RNE.
module fp_mul_round_norm
    import fp_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_sign,
    input  logic signed [fp_e(N)+1:0]     in_exp,
    input  logic [2*fp_m(N)+1:0]          in_mant,
    input  logic [1:0]                    in_class,
`ifdef FP_RND_MODE_EN
    input  logic [1:0]                    rnd_mode,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N-1:0]                  out_result,
    output logic [3:0]                    out_flags
);

    localparam int M    = fp_m(N);
    localparam int E    = fp_e(N);
    localparam int BIAS = fp_bias(N);
    localparam logic signed [E+1:0] BIAS_S  = (E+2)'(BIAS);
    localparam logic signed [E+1:0] BE_MAX  = (E+2)'((1 << E) - 1);
    localparam logic signed [E+1:0] BE_ZERO = '0;

    logic                  w_s2_load;
    logic                  w_norm;
    logic [M-1:0]          w_frac1;
    logic                  w_g1;
    logic                  w_st1;
    logic signed [E+1:0]   w_be1;
    fp_class_e             w_cls;
    logic                  w_ovr;
    logic                  w_ovr_nan;
    logic [N-1:0]          w_ovr_res;

    logic                  r_s1_valid;
    logic                  r_s1_sign;
    logic signed [E+1:0]   r_s1_be;
    logic [M-1:0]          r_s1_frac;
    logic                  r_s1_g;
    logic                  r_s1_st;
    logic                  r_s1_ovr;
    logic                  r_s1_ovr_nan;
    logic [N-1:0]          r_s1_ovr_res;
    fp_rnd_e               w_mode;

    logic [M-1:0]          w_rfrac;
    logic                  w_carry;
    logic signed [E+1:0]   w_be2;
    logic                  w_ovf;
    logic                  w_unf;
    logic                  w_to_inf;
    logic [N-1:0]          w_res;
    logic [3:0]            w_flags;

    logic                  r_out_valid;
    logic [N-1:0]          r_out_result;
    logic [3:0]            r_out_flags;

    assign w_s2_load = ~r_out_valid | out_ready;
    assign in_ready  = ~r_s1_valid | w_s2_load;

    // Stage 1: normalise the product, split off guard/sticky, bias the exponent
    assign w_norm = in_mant[2*M+1];
    assign w_cls  = fp_class_e'(in_class);

    always_comb begin
        if (w_norm) begin
            w_frac1 = in_mant[2*M:M+1];
            w_g1    = in_mant[M];
            w_st1   = |in_mant[M-1:0];
        end else begin
            w_frac1 = in_mant[2*M-1:M];
            w_g1    = in_mant[M-1];
            w_st1   = |in_mant[M-2:0];
        end
    end

    assign w_be1 = in_exp + BIAS_S + (w_norm ? (E+2)'(1) : '0);

    always_comb begin
        w_ovr     = 1'b1;
        w_ovr_nan = 1'b0;
        w_ovr_res = '0;
        case (w_cls)
            FP_ZERO: w_ovr_res = {in_sign, {(N-1){1'b0}}};
            FP_INF:  w_ovr_res = {in_sign, {E{1'b1}}, {M{1'b0}}};
            FP_NAN: begin
                w_ovr_res = {1'b0, {(N-1){1'b1}}};
                w_ovr_nan = 1'b1;
            end
            default: w_ovr = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            r_s1_sign    <= in_sign;
            r_s1_be      <= w_be1;
            r_s1_frac    <= w_frac1;
            r_s1_g       <= w_g1;
            r_s1_st      <= w_st1;
            r_s1_ovr     <= w_ovr;
            r_s1_ovr_nan <= w_ovr_nan;
            r_s1_ovr_res <= w_ovr_res;
        end
    end

`ifdef FP_RND_MODE_EN
    fp_rnd_e r_s1_mode;

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            r_s1_mode <= fp_rnd_e'(rnd_mode);
        end
    end

    assign w_mode = r_s1_mode;
`else
    assign w_mode = RND_RNE;
`endif

    // Stage 2: round, then saturate to inf/max-finite or flush to signed zero
    fp_round_core #(
        .M (M)
    ) u_round (
        .i_frac   (r_s1_frac),
        .i_guard  (r_s1_g),
        .i_sticky (r_s1_st),
        .i_sign   (r_s1_sign),
        .i_mode   (w_mode),
        .o_frac   (w_rfrac),
        .o_carry  (w_carry)
    );

    assign w_be2    = r_s1_be + (w_carry ? (E+2)'(1) : '0);
    assign w_ovf    = (w_be2 >= BE_MAX);
    assign w_unf    = (w_be2 <= BE_ZERO);
    assign w_to_inf = (w_mode == RND_RNE) |
                      ((w_mode == RND_RUP) & ~r_s1_sign) |
                      ((w_mode == RND_RDN) & r_s1_sign);

    always_comb begin
        w_res   = {r_s1_sign, w_be2[E-1:0], w_rfrac};
        w_flags = '0;
        if (r_s1_ovr) begin
            w_res            = r_s1_ovr_res;
            w_flags[FLG_NAN] = r_s1_ovr_nan;
        end else if (w_ovf) begin
            w_res = w_to_inf ? {r_s1_sign, {E{1'b1}}, {M{1'b0}}}
                             : {r_s1_sign, {(E-1){1'b1}}, 1'b0, {M{1'b1}}};
            w_flags[FLG_OVF] = 1'b1;
            w_flags[FLG_INX] = 1'b1;
        end else if (w_unf) begin
            w_res            = {r_s1_sign, {(N-1){1'b0}}};
            w_flags[FLG_UNF] = 1'b1;
            w_flags[FLG_INX] = 1'b1;
        end else begin
            w_flags[FLG_INX] = r_s1_g | r_s1_st;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_flags  <= '0;
        end else if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_result <= w_res;
                r_out_flags  <= w_flags;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_flags  = r_out_flags;

endmodule

// File: tb/tb_fp_mul_round_norm.sv
// Directed, table-driven bench for fp_mul_round_norm (N=32) plus backpressure and reset sequences.
module tb_fp_mul_round_norm;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid;
    logic               in_ready;
    logic               in_sign;
    logic signed [9:0]  in_exp;
    logic [47:0]        in_mant;
    logic [1:0]         in_class;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_result;
    logic [3:0]         out_flags;

    fp_mul_round_norm #(.N(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .in_class   (in_class),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              sign;
        logic signed [9:0] exp;
        logic [47:0]       mant;
        logic [1:0]        cls;
        logic [31:0]       res;
        logic [3:0]        flg;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    int n_pass  = 0;
    int n_total = 0;

    function automatic vec_t mk(input logic s, input logic signed [9:0] e, input logic [47:0] m,
                                input logic [1:0] c, input logic [31:0] r, input logic [3:0] f);
        vec_t v;
        v.sign = s; v.exp = e; v.mant = m; v.cls = c; v.res = r; v.flg = f;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        in_sign  = v.sign;
        in_exp   = v.exp;
        in_mant  = v.mant;
        in_class = v.cls;
    endtask

    task automatic run_one(input int i);
        int lat;
        bit got;
        @(negedge clk);
        drive(vecs[i]);
        chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        got = 1'b0;
        while (lat <= 8) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        chk($sformatf("vec%0d latency", i), 64'(lat), 64'(2));
        if (got) begin
            chk($sformatf("vec%0d result", i), 64'(out_result), 64'(vecs[i].res));
            chk($sformatf("vec%0d flags", i), 64'(out_flags), 64'(vecs[i].flg));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        bit stale;

        // flags column is {inexact, underflow, overflow, nan}
        vecs[0]  = mk(0,    0, 48'h9000_0000_0000, 2'b00, 32'h4010_0000, 4'b0000);
        vecs[1]  = mk(0,    0, 48'h4000_0040_0000, 2'b00, 32'h3F80_0000, 4'b1000);
        vecs[2]  = mk(0,    0, 48'h4000_00C0_0000, 2'b00, 32'h3F80_0002, 4'b1000);
        vecs[3]  = mk(0,    0, 48'h7FFF_FFC0_0000, 2'b00, 32'h4000_0000, 4'b1000);
        vecs[4]  = mk(0,  128, 48'h4000_0000_0000, 2'b00, 32'h7F80_0000, 4'b1010);
        vecs[5]  = mk(1,  128, 48'h4000_0000_0000, 2'b00, 32'hFF80_0000, 4'b1010);
        vecs[6]  = mk(1, -127, 48'h4000_0000_0000, 2'b00, 32'h8000_0000, 4'b1100);
        vecs[7]  = mk(0,    0, 48'h0,              2'b11, 32'h7FFF_FFFF, 4'b0001);
        vecs[8]  = mk(1,    0, 48'h0,              2'b10, 32'hFF80_0000, 4'b0000);
        vecs[9]  = mk(1,    0, 48'h0,              2'b01, 32'h8000_0000, 4'b0000);
        vecs[10] = mk(0,    0, 48'h4000_0000_0000, 2'b00, 32'h3F80_0000, 4'b0000);
        vecs[11] = mk(0,   -1, 48'h9000_0000_0000, 2'b00, 32'h3F90_0000, 4'b0000);
        vecs[12] = mk(0,    0, 48'h4000_0040_0001, 2'b00, 32'h3F80_0001, 4'b1000);
        vecs[13] = mk(0,  127, 48'h4000_0000_0000, 2'b00, 32'h7F00_0000, 4'b0000);
        vecs[14] = mk(0, -126, 48'h4000_0000_0000, 2'b00, 32'h0080_0000, 4'b0000);
        vecs[15] = mk(0,  127, 48'h7FFF_FFC0_0000, 2'b00, 32'h7F80_0000, 4'b1010);

        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        in_class  = 2'b00;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset out_valid", 64'(out_valid), 64'(0));
        chk("reset out_result", 64'(out_result), 64'(0));
        chk("reset out_flags", 64'(out_flags), 64'(0));
        chk("reset in_ready", 64'(in_ready), 64'(1));
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) run_one(i);

        // Back-to-back stream at full throughput
        for (int t = 0; t < 7; t++) begin
            @(negedge clk);
            if (t >= 2) begin
                chk($sformatf("stream%0d valid", t - 2), 64'(out_valid), 64'(1));
                chk($sformatf("stream%0d result", t - 2), 64'(out_result), 64'(vecs[t-2].res));
            end
            if (t < 5) drive(vecs[t]);
            else in_valid = 1'b0;
            chk($sformatf("stream t%0d in_ready", t), 64'(in_ready), 64'(1));
        end
        @(negedge clk);
        chk("stream drained", 64'(out_valid), 64'(0));

        // Backpressure: three offered, two fit, output held stable
        out_ready = 1'b0;
        acc = 0;
        @(negedge clk);
        drive(vecs[0]);
        if (in_ready) acc++;
        @(posedge clk);
        @(negedge clk);
        drive(vecs[1]);
        if (in_ready) acc++;
        @(posedge clk);
        @(negedge clk);
        drive(vecs[2]);
        chk("bp in_ready low", 64'(in_ready), 64'(0));
        chk("bp first valid", 64'(out_valid), 64'(1));
        chk("bp first result", 64'(out_result), 64'(vecs[0].res));
        if (in_ready) acc++;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp hold%0d in_ready", k), 64'(in_ready), 64'(0));
            chk($sformatf("bp hold%0d result", k), 64'(out_result), 64'(vecs[0].res));
            chk($sformatf("bp hold%0d flags", k), 64'(out_flags), 64'(vecs[0].flg));
            if (in_ready) acc++;
        end
        chk("bp accepted", 64'(acc), 64'(2));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp second valid", 64'(out_valid), 64'(1));
        chk("bp second result", 64'(out_result), 64'(vecs[1].res));
        @(posedge clk);
        @(negedge clk);
        chk("bp third valid", 64'(out_valid), 64'(1));
        chk("bp third result", 64'(out_result), 64'(vecs[2].res));
        @(posedge clk);
        @(negedge clk);
        chk("bp no duplicate", 64'(out_valid), 64'(0));

        // Asynchronous reset with both stages occupied
        out_ready = 1'b0;
        @(negedge clk);
        drive(vecs[3]);
        @(posedge clk);
        @(negedge clk);
        drive(vecs[4]);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst full valid", 64'(out_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("rst async valid", 64'(out_valid), 64'(0));
        chk("rst async result", 64'(out_result), 64'(0));
        chk("rst async flags", 64'(out_flags), 64'(0));
        chk("rst async in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        chk("rst no stale output", 64'(stale), 64'(0));

        run_one(11);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
